// File: rtl/kernel_buffer_loader_pkg.sv
// kernel_buffer_loader_pkg
//   Shared definitions for the kernel buffer loader and the kernel buffer:
//   - loader FSM state encoding
//   - ioInputs field offsets, so the packing
//     {ioSelect, ioWrite, ioBankSelect, ioInput} is defined in one place
//   The default configuration constants are the values the loader and its
//   interface use when not overridden.
package kernel_buffer_loader_pkg;

  localparam int KBL_DEPTH = 2;
  localparam int KBL_A     = 7;
  localparam int KBL_W     = 16;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    FLUSH = 2'd2,
    DONE  = 2'd3
  } kbl_state_t;

  // Field offsets inside ioInputs for a given word width / bank log2.
  function automatic int io_bank_lsb(input int w);
    return w;
  endfunction

  function automatic int io_wr(input int w, input int depth);
    return w + depth;
  endfunction

  function automatic int io_sel(input int w, input int depth);
    return w + depth + 1;
  endfunction

  localparam int IO_BANK_LSB = KBL_W;
  localparam int IO_WR       = KBL_W + KBL_DEPTH;
  localparam int IO_SEL      = KBL_W + KBL_DEPTH + 1;

endpackage

// File: rtl/kernel_buffer_loader_if.sv
// kernel_buffer_loader_if
//   Control, stream and kernel-buffer bus of the kernel buffer loader.
//   master : controller / stream source / buffer side
//   slave  : the loader itself
//   Signals: start, num_words, in_data, in_valid, in_ready, address,
//            ioInputs, busy, done (+ checksum when KBL_CHECKSUM_EN is defined)
interface kernel_buffer_loader_if
  import kernel_buffer_loader_pkg::*;
#(
  parameter int depth = KBL_DEPTH,
  parameter int A     = KBL_A,
  parameter int W     = KBL_W
);
  logic                 start;
  logic [A+depth:0]     num_words;
  logic [W-1:0]         in_data;
  logic                 in_valid;
  logic                 in_ready;
  logic [A-1:0]         address;
  logic [W+depth+1:0]   ioInputs;
  logic                 busy;
  logic                 done;
`ifdef KBL_CHECKSUM_EN
  logic [W-1:0]         checksum;
`endif

  modport master (
    output start, num_words, in_data, in_valid,
    input  in_ready, address, ioInputs, busy, done
`ifdef KBL_CHECKSUM_EN
    , input checksum
`endif
  );

  modport slave (
    input  start, num_words, in_data, in_valid,
    output in_ready, address, ioInputs, busy, done
`ifdef KBL_CHECKSUM_EN
    , output checksum
`endif
  );
endinterface

// File: rtl/kernel_buffer_loader_bank_addr_counter.sv
// kbl_bank_addr_counter
//   Round-robin write position: bank_cnt walks 0..D-1 per accepted word and
//   addr_cnt advances each time bank_cnt wraps (word k -> bank k%D, addr k/D).
//   Ports: clk, rst (async, active high), clr (sync clear), inc (advance),
//          bank_cnt [depth-1:0], addr_cnt [A-1:0]
module kbl_bank_addr_counter #(
  parameter int depth = 2,
  parameter int A     = 7
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             inc,
  output logic [depth-1:0] bank_cnt,
  output logic [A-1:0]     addr_cnt
);
  localparam logic [depth-1:0] BANK_LAST = {depth{1'b1}};
  localparam logic [depth-1:0] BANK_ONE  = 1;
  localparam logic [A-1:0]     ADDR_ONE  = 1;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (clr) begin
      bank_cnt <= '0;
      addr_cnt <= '0;
    end else if (inc) begin
      if (bank_cnt == BANK_LAST) begin
        bank_cnt <= '0;
        addr_cnt <= addr_cnt + ADDR_ONE;
      end else begin
        bank_cnt <= bank_cnt + BANK_ONE;
      end
    end
  end
endmodule

// File: rtl/kernel_buffer_loader.sv
// kernel_buffer_loader
//   Accepts a valid/ready stream of W-bit kernel words and writes them
//   round-robin across the D banks of the kernel buffer through its packed
//   io bus, driving the shared address port while a load is in progress.
//   Ports: CLK, RST (async, active high), bus (kernel_buffer_loader_if.slave)
//   Optional feature: KBL_CHECKSUM_EN adds bus.checksum, the modulo-2^W sum
//   of the words accepted since the last accepted start.
module kernel_buffer_loader
  import kernel_buffer_loader_pkg::*;
#(
  parameter int depth = KBL_DEPTH,
  parameter int A     = KBL_A,
  parameter int W     = KBL_W
) (
  input logic                   CLK,
  input logic                   RST,
  kernel_buffer_loader_if.slave bus
);
  localparam int NW       = A + depth + 1;
  localparam int SEL_POS  = io_sel(W, depth);
  localparam int WR_POS   = io_wr(W, depth);
  localparam int BANK_POS = io_bank_lsb(W);
  // D<<A: the full buffer capacity in words
  localparam logic [NW-1:0] MAX_WORDS = {1'b1, {(NW-1){1'b0}}};
  localparam logic [NW-1:0] ONE_WORD  = 1;

  kbl_state_t         state;
  logic [NW-1:0]      remaining;
  logic               in_ready_reg;
  logic               busy_reg;
  logic               done_reg;
  logic               sel_reg;
  logic               wr_reg;
  logic [depth-1:0]   bank_reg;
  logic [A-1:0]       addr_reg;
  logic [W-1:0]       data_reg;
  logic [depth-1:0]   bank_cnt;
  logic [A-1:0]       addr_cnt;
  logic [W+depth+1:0] io_bus;
  logic               accept;
  logic               start_accept;

  assign accept       = (state == LOAD) && bus.in_valid && in_ready_reg;
  assign start_accept = (state == IDLE) && bus.start;

  kbl_bank_addr_counter #(.depth(depth), .A(A)) u_counter (
    .clk      (CLK),
    .rst      (RST),
    .clr      (start_accept),
    .inc      (accept),
    .bank_cnt (bank_cnt),
    .addr_cnt (addr_cnt)
  );

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state        <= IDLE;
      remaining    <= '0;
      in_ready_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
      sel_reg      <= 1'b0;
      wr_reg       <= 1'b0;
      bank_reg     <= '0;
      addr_reg     <= '0;
      data_reg     <= '0;
    end else begin
      // write strobe and done are single-cycle unless re-asserted below
      wr_reg   <= 1'b0;
      done_reg <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            busy_reg  <= 1'b1;
            remaining <= (bus.num_words > MAX_WORDS) ? MAX_WORDS : bus.num_words;
            if (bus.num_words == '0) begin
              // empty load: skip straight to the done pulse, never touch the buffer
              state    <= DONE;
              done_reg <= 1'b1;
            end else begin
              state        <= LOAD;
              in_ready_reg <= 1'b1;
              sel_reg      <= 1'b1;
            end
          end
        end
        LOAD: begin
          if (accept) begin
            wr_reg    <= 1'b1;
            data_reg  <= bus.in_data;
            bank_reg  <= bank_cnt;
            addr_reg  <= addr_cnt;
            remaining <= remaining - ONE_WORD;
            if (remaining == ONE_WORD) begin
              in_ready_reg <= 1'b0;
              state        <= FLUSH;
            end
          end
        end
        FLUSH: begin
          // this cycle presents the last write; ioSelect drops with it
          sel_reg  <= 1'b0;
          done_reg <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          busy_reg <= 1'b0;
          state    <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  always_comb begin
    io_bus                      = '0;
    io_bus[SEL_POS]             = sel_reg;
    io_bus[WR_POS]              = wr_reg;
    io_bus[BANK_POS +: depth]   = bank_reg;
    io_bus[W-1:0]               = data_reg;
  end

  assign bus.ioInputs = io_bus;
  assign bus.address  = addr_reg;
  assign bus.in_ready = in_ready_reg;
  assign bus.busy     = busy_reg;
  assign bus.done     = done_reg;

`ifdef KBL_CHECKSUM_EN
  logic [W-1:0] checksum_reg;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      checksum_reg <= '0;
    end else if (start_accept) begin
      checksum_reg <= '0;
    end else if (accept) begin
      checksum_reg <= checksum_reg + bus.in_data;
    end
  end

  assign bus.checksum = checksum_reg;
`endif

endmodule
